// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the memory arbiter.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_CORE_NUM    = 2;
    localparam int DEF_MEM_LATENCY = 1;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner selection among requesting cores.
// MEM_ARB_ROUND_ROBIN_EN: search from pointer+1; otherwise lowest index wins.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int CORE_NUM = DEF_CORE_NUM,
    parameter int IDXW     = $clog2(CORE_NUM)
) (
    input  logic [CORE_NUM-1:0] i_request,
    input  logic [IDXW-1:0]     i_pointer,
    output logic [IDXW-1:0]     o_winner,
    output logic                o_valid
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Descending scan: the last hit (offset 1) has the highest priority.
    always_comb begin
        logic [IDXW-1:0] w_idx;
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int k = CORE_NUM; k >= 1; k--) begin
            w_idx = IDXW'((int'(i_pointer) + k) % CORE_NUM);
            if (i_request[w_idx]) begin
                o_winner = w_idx;
                o_valid  = 1'b1;
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_pointer;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int i = CORE_NUM - 1; i >= 0; i--) begin
            if (i_request[i]) begin
                o_winner = IDXW'(i);
                o_valid  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Multi-core single-port memory arbiter, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CORE_NUM    = DEF_CORE_NUM,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CORE_NUM-1:0]          request,
    input  logic [CORE_NUM-1:0]          wren,
    input  logic [CORE_NUM*WIDTH-1:0]    address,
    input  logic [CORE_NUM*WIDTH-1:0]    writedata,
    output logic [CORE_NUM-1:0]          response,
    output logic [WIDTH-1:0]             readdata,
    output logic [$clog2(CORE_NUM)-1:0]  grant_idx,
    output logic [WIDTH-1:0]             mem_address,
    output logic [WIDTH-1:0]             mem_writedata,
    output logic                         mem_wren,
    output logic                         mem_rden,
    input  logic [WIDTH-1:0]             mem_readdata
);

    localparam int IDXW = $clog2(CORE_NUM);
    localparam int CNTW = $clog2(MEM_LATENCY + 1);

    state_t          r_state;
    state_t          w_next;
    logic [IDXW-1:0] r_grant;
    logic [IDXW-1:0] w_ptr;
    logic [IDXW-1:0] w_winner;
    logic            w_valid;
    logic            w_take;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_readdata;
    logic            r_wr;
    logic [CNTW-1:0] r_cnt;

    assign w_take    = (r_state == IDLE) && w_valid;
    assign grant_idx = r_grant;
    assign readdata  = r_readdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] r_ptr;

    // Reset to the last index so core 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= IDXW'(CORE_NUM - 1);
        end else if (w_take) begin
            r_ptr <= w_winner;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = IDXW'(CORE_NUM - 1);
`endif

    rr_picker #(
        .CORE_NUM (CORE_NUM),
        .IDXW     (IDXW)
    ) u_picker (
        .i_request (request),
        .i_pointer (w_ptr),
        .o_winner  (w_winner),
        .o_valid   (w_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        response      = '0;
        mem_wren      = 1'b0;
        mem_rden      = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_address   = r_addr;
                mem_writedata = r_wdata;
                mem_wren      = r_wr;
                mem_rden      = !r_wr;
                w_next        = r_wr ? RESP : WAIT;
            end
            WAIT: begin
                if (r_cnt == CNTW'(1)) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                response[r_grant] = 1'b1;
                w_next            = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr       <= 1'b0;
            r_cnt      <= '0;
            r_readdata <= '0;
        end else begin
            if (w_take) begin
                r_grant <= w_winner;
                r_addr  <= address[w_winner*WIDTH +: WIDTH];
                r_wdata <= writedata[w_winner*WIDTH +: WIDTH];
                r_wr    <= wren[w_winner];
            end
            if (r_state == ISSUE && !r_wr) begin
                r_cnt <= CNTW'(MEM_LATENCY);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    r_readdata <= mem_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model.
// Honours MEM_ARB_ROUND_ROBIN_EN for the expected arbitration order.
module tb_mem_arbiter;

    localparam int N    = 3;
    localparam int W    = 32;
    localparam int L    = 3;
    localparam int NCYC = 2000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    request;
    logic [N-1:0]    wren;
    logic [N*W-1:0]  address;
    logic [N*W-1:0]  writedata;
    logic [N-1:0]    response;
    logic [W-1:0]    readdata;
    logic [1:0]      grant_idx;
    logic [W-1:0]    mem_address;
    logic [W-1:0]    mem_writedata;
    logic            mem_wren;
    logic            mem_rden;
    logic [W-1:0]    mem_readdata;

    mem_arbiter #(
        .WIDTH       (W),
        .CORE_NUM    (N),
        .MEM_LATENCY (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .wren          (wren),
        .address       (address),
        .writedata     (writedata),
        .response      (response),
        .readdata      (readdata),
        .grant_idx     (grant_idx),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_wren      (mem_wren),
        .mem_rden      (mem_rden),
        .mem_readdata  (mem_readdata)
    );

    always #5 clk = ~clk;

    int         n_checks;
    int         n_errors;
    int         cyc;
    logic [W-1:0] mem_hist [NCYC];
    bit         pend [N];
    bit         inflight [N];
    bit         c_wr [N];
    logic [W-1:0] c_addr [N];
    logic [W-1:0] c_wdata [N];
    int         issue_cyc;
    int         resp_cyc;
    int         next_free;
    int         last_grant;
    int         tr_core;
    bit         tr_wr;
    logic [W-1:0] tr_addr;
    logic [W-1:0] tr_wdata;
    logic [W-1:0] exp_rd;
    int         exp_grant;
    bit         did_mid;
    bit         midrst;
    int         w;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     tag, cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        int res;
        res = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (res < 0 && r[(last_grant + k) % N]) res = (last_grant + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (res < 0 && r[i]) res = i;
        end
`endif
        return res;
    endfunction

    task automatic model_reset();
        issue_cyc  = -10;
        resp_cyc   = -10;
        next_free  = 0;
        last_grant = N - 1;
        exp_grant  = 0;
        exp_rd     = '0;
        for (int i = 0; i < N; i++) inflight[i] = 1'b0;
    endtask

    task automatic new_fields(input int i);
        c_wr[i]    = 1'($urandom_range(1));
        c_addr[i]  = $urandom;
        c_wdata[i] = $urandom;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        did_mid      = 1'b0;
        request      = '0;
        wren         = '0;
        address      = '0;
        writedata    = '0;
        mem_readdata = '0;
        tr_core      = 0;
        tr_wr        = 1'b0;
        tr_addr      = '0;
        tr_wdata     = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            new_fields(i);
        end
        model_reset();

        for (cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            mem_readdata  = $urandom;
            mem_hist[cyc] = mem_readdata;
            midrst = !did_mid && cyc > 300 && !tr_wr && cyc == issue_cyc + 2;
            if (cyc < 2 || midrst) begin
                rst = 1'b1;
                #1;
                model_reset();
                if (midrst) begin
                    did_mid = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        if (!pend[i]) new_fields(i);
                        pend[i] = 1'b1;
                    end
                end
            end else begin
                rst = 1'b0;
            end

            if (cyc == resp_cyc && !tr_wr) exp_rd = mem_hist[issue_cyc + L];
            chk("mem_wren", mem_wren, (cyc == issue_cyc) && tr_wr);
            chk("mem_rden", mem_rden, (cyc == issue_cyc) && !tr_wr);
            chk("mem_address", mem_address, (cyc == issue_cyc) ? tr_addr : '0);
            chk("mem_writedata", mem_writedata,
                (cyc == issue_cyc) ? tr_wdata : '0);
            chk("response", response,
                (cyc == resp_cyc) ? (64'd1 << tr_core) : 64'd0);
            chk("grant_idx", grant_idx, exp_grant);
            chk("readdata", readdata, exp_rd);

            for (int i = 0; i < N; i++) begin
                if (cyc == resp_cyc && i == tr_core) pend[i] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && !inflight[i] && $urandom_range(3) == 0) begin
                    new_fields(i);
                    pend[i] = 1'b1;
                end
            end
            // Drop a granted request early and scramble its fields.
            for (int i = 0; i < N; i++) begin
                if (inflight[i] && pend[i] && cyc < resp_cyc &&
                    $urandom_range(4) == 0) begin
                    pend[i] = 1'b0;
                    new_fields(i);
                end
            end
            if (cyc == resp_cyc) inflight[tr_core] = 1'b0;

            for (int i = 0; i < N; i++) begin
                request[i]           = pend[i];
                wren[i]              = c_wr[i];
                address[i*W +: W]    = c_addr[i];
                writedata[i*W +: W]  = c_wdata[i];
            end

            if (!rst && cyc >= next_free && request != '0) begin
                w          = pick(request);
                tr_core    = w;
                tr_wr      = c_wr[w];
                tr_addr    = c_addr[w];
                tr_wdata   = c_wdata[w];
                issue_cyc  = cyc + 1;
                resp_cyc   = cyc + 2 + (tr_wr ? 0 : L);
                next_free  = resp_cyc + 1;
                last_grant = w;
                exp_grant  = w;
                inflight[w] = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data/address width in bits.
REQ-002 Parameter CORE_NUM, default 2, number of requesting cores (>=2).
REQ-003 Parameter MEM_LATENCY, default 1, cycles from mem_rden to valid mem_readdata (>=1).
REQ-004 Clock and reset SHALL be: one clock `clk`; reset `rst` is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 request  in  CORE_NUM  per-core access request, level, held until response.
REQ-008 wren  in  CORE_NUM  per-core write qualifier, valid while request high.
REQ-009 address  in  CORE_NUM*WIDTH  per-core address, core i at bits [i*WIDTH +: WIDTH].
REQ-010 writedata  in  CORE_NUM*WIDTH  per-core write data, same packing.
REQ-011 response  out  CORE_NUM  one-hot, one-cycle completion pulse.
REQ-012 readdata  out  WIDTH  registered read data, broadcast to all cores.
REQ-013 grant_idx  out  $clog2(CORE_NUM)  index of the core currently or last served.
REQ-014 mem_address / mem_writedata  out  WIDTH each  memory port address and data.
REQ-015 mem_wren / mem_rden  out  1 each  one-cycle memory write / read strobes.
REQ-016 mem_readdata  in  WIDTH  memory read data.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-018 IDLE: if any request bit is high, select a winner, latch its address, writedata, wren and index, then go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: drive mem_address/mem_writedata from the latches for exactly one cycle and pulse mem_wren (write) or mem_rden (read); go to RESP on a write, or to WAIT with the counter loaded to MEM_LATENCY on a read.
REQ-020 WAIT: decrement the counter each cycle; on the cycle it reads 1, register mem_readdata into readdata and go to RESP.
REQ-021 RESP: assert response[grant_idx] for exactly one cycle, then go to IDLE.
REQ-022 Latency: with request sampled in IDLE at cycle t, a write response SHALL occur at t+2 and a read response at t+2+MEM_LATENCY.
REQ-023 readdata SHALL hold its value until the next read completes; it is unchanged by writes.
REQ-024 A request dropped mid-transaction SHALL NOT abort it; the response still pulses.
REQ-025 A requester SHALL deassert request by the cycle after its response pulse; the arbiter samples requests only in IDLE.
REQ-026 mem_wren, mem_rden and response SHALL be 0 in every state other than those stated above.
REQ-027 When several requests are high, selection SHALL follow REQ-030/031; no requester waits more than CORE_NUM-1 transactions under round-robin.

Reset
REQ-028 On rst: state=IDLE; response, mem_wren, mem_rden = 0; readdata, mem_address, mem_writedata, counter = 0.
REQ-029 On rst: grant_idx=0 and the round-robin pointer = CORE_NUM-1, so core 0 has first priority; reset mid-transaction abandons it silently with no response.

Configuration
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first requesting index searched cyclically from (last grant + 1) mod CORE_NUM, and the pointer SHALL update on each grant.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, lowest requesting index wins, and no pointer register is built.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP) and the default-parameter constants.
REQ-033 Winner selection SHALL be the combinational sub-module rr_picker (inputs: request vector and pointer; output: winner index and valid).

Verification
REQ-034 Single read: core0 reads 0x10 at t, MEM_LATENCY=1, memory returns 0xDEADBEEF -> mem_rden at t+1, response=2'b01 at t+3, readdata=0xDEADBEEF.
REQ-035 Single write: core1 writes 0x1234 to 0x20 -> mem_wren pulses with addr 0x20 and data 0x1234 at t+1; response=2'b10 at t+2; readdata unchanged.
REQ-036 Contention (RR on): both cores hold reads continuously -> grants alternate 0,1,0,1; with the macro off -> core0 always wins while it keeps requesting.
REQ-037 Latency sweep: MEM_LATENCY=3 read -> response at t+5, and the data captured is the value present 3 cycles after mem_rden.
REQ-038 Reset mid-WAIT: assert rst during WAIT -> no response pulse, all outputs 0, next grant goes to core0.
REQ-039 Request drop: core0 drops request in ISSUE -> transaction completes, response[0] still pulses, FSM returns to IDLE.
